// File: rtl/hazard_unit.sv
// hazard_unit
//
// Hazard detection and forwarding controller for a five-stage pipeline.
//
// The unit looks at the execute-stage bundle held in the decode-to-execute
// register and at the decode-stage source addresses. From these it produces:
//   - the stall and flush controls for the front of the pipeline, and
//   - the ALU operand forward selects.
//
// It keeps a private shadow of the memory- and writeback-stage destination
// tags. These tags advance on every clock and are never stalled. When the
// pipeline inserts a bubble, flush_e zeroes the execute bundle, and that zero
// bundle is what the shadow captures, so no extra kill path is needed here.
//
// Two saturating event counters (stall cycles, redirect cycles) are provided
// for performance debug.
//
// Ports
//   clk, rst_n          pipeline clock; asynchronous active-low reset
//   d_ra1, d_ra2        decode-stage source register addresses
//   e_ra1, e_ra2        execute-stage source register addresses
//   e_rd                execute-stage destination register
//   e_regwrite          execute-stage instruction writes the register file
//   e_resultsrc         execute-stage result select (2'b01 = load)
//   e_pcsrc             taken branch / jump resolved in execute this cycle
//   cnt_clr             synchronous clear of both event counters
//   fwd_a, fwd_b        operand forward selects
//                       (00 regfile, 10 memory-stage ALU result,
//                        01 writeback result)
//   stall_f, stall_d    hold the PC and the fetch-to-decode register
//   flush_d             bubble the fetch-to-decode register
//   flush_e             bubble the decode-to-execute register
//   stall_cnt           saturating count of stall cycles
//   flush_cnt           saturating count of redirect cycles

module hazard_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,

  // Decode-stage sources
  input  logic [4:0]           d_ra1,
  input  logic [4:0]           d_ra2,

  // Execute-stage bundle
  input  logic [4:0]           e_ra1,
  input  logic [4:0]           e_ra2,
  input  logic [4:0]           e_rd,
  input  logic                 e_regwrite,
  input  logic [1:0]           e_resultsrc,
  input  logic                 e_pcsrc,

  // Counter control
  input  logic                 cnt_clr,

  // Forwarding
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,

  // Pipeline controls
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,

  // Event counters
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b01;

  localparam logic [4:0] REG_ZERO    = 5'd0;

  // ---------------------------------------------------------------------------
  // Shadow destination tags
  // ---------------------------------------------------------------------------

  // Memory stage
  logic [4:0] m_rd_q, m_rd_d;
  logic       m_regwrite_q, m_regwrite_d;
  logic [1:0] m_resultsrc_q, m_resultsrc_d;

  // Writeback stage
  logic [4:0] w_rd_q, w_rd_d;
  logic       w_regwrite_q, w_regwrite_d;

  always_comb begin
    m_rd_d        = e_rd;
    m_regwrite_d  = e_regwrite;
    m_resultsrc_d = e_resultsrc;
    w_rd_d        = m_rd_q;
    w_regwrite_d  = m_regwrite_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd_q        <= REG_ZERO;
      m_regwrite_q  <= 1'b0;
      m_resultsrc_q <= 2'b00;
      w_rd_q        <= REG_ZERO;
      w_regwrite_q  <= 1'b0;
    end else begin
      m_rd_q        <= m_rd_d;
      m_regwrite_q  <= m_regwrite_d;
      m_resultsrc_q <= m_resultsrc_d;
      w_rd_q        <= w_rd_d;
      w_regwrite_q  <= w_regwrite_d;
    end
  end

  // The memory-stage result select is tracked alongside the other memory-stage
  // tags, but forwarding from memory always takes the ALU result, so the
  // select itself does not steer anything in this unit.
  logic unused_m_resultsrc;
  assign unused_m_resultsrc = ^m_resultsrc_q;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------

  // A stage can supply a value only if it writes a real register; x0 is
  // hard-wired to zero and must never be forwarded.
  logic m_writes_reg;
  logic w_writes_reg;

  always_comb begin
    m_writes_reg = m_regwrite_q && (m_rd_q != REG_ZERO);
    w_writes_reg = w_regwrite_q && (w_rd_q != REG_ZERO);
  end

  // Memory stage holds the newer value, so it is checked first.
  always_comb begin
    fwd_a = FWD_REGFILE;
    if (m_writes_reg && (m_rd_q == e_ra1)) begin
      fwd_a = FWD_MEM;
    end else if (w_writes_reg && (w_rd_q == e_ra1)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_REGFILE;
    if (m_writes_reg && (m_rd_q == e_ra2)) begin
      fwd_b = FWD_MEM;
    end else if (w_writes_reg && (w_rd_q == e_ra2)) begin
      fwd_b = FWD_WB;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use detection and pipeline controls
  // ---------------------------------------------------------------------------

  logic e_is_load;
  logic lw_hazard;

  always_comb begin
    e_is_load = (e_resultsrc == RESULT_LOAD) && e_regwrite && (e_rd != REG_ZERO);
    lw_hazard = e_is_load && ((e_rd == d_ra1) || (e_rd == d_ra2));
  end

  // A redirect discards the instruction in decode, so there is nothing left
  // to hold: e_pcsrc suppresses the stall and flushes both front registers.
  always_comb begin
    stall_f = lw_hazard && !e_pcsrc;
    stall_d = lw_hazard && !e_pcsrc;
    flush_d = e_pcsrc;
    flush_e = lw_hazard || e_pcsrc;
  end

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Clear wins over an increment in the same cycle; a full counter holds.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_d && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      flush_cnt_d = '0;
    end else if (e_pcsrc && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors, a history-based reference model
// checked every cycle, and literal expectations at key points.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] d_ra1 = '0, d_ra2 = '0, e_ra1 = '0, e_ra2 = '0, e_rd = '0;
  logic e_regwrite = 1'b0;
  logic [1:0] e_resultsrc = '0;
  logic e_pcsrc = 1'b0;
  logic cnt_clr = 1'b0;

  logic [1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic stall_f, stall_d, flush_d, flush_e;
  logic stall_f4, stall_d4, flush_d4, flush_e4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .e_ra1(e_ra1), .e_ra2(e_ra2), .e_rd(e_rd), .e_regwrite(e_regwrite),
    .e_resultsrc(e_resultsrc), .e_pcsrc(e_pcsrc), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .e_ra1(e_ra1), .e_ra2(e_ra2), .e_rd(e_rd), .e_regwrite(e_regwrite),
    .e_resultsrc(e_resultsrc), .e_pcsrc(e_pcsrc), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_f(stall_f4), .stall_d(stall_d4),
    .flush_d(flush_d4), .flush_e(flush_e4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
  } prod_t;

  // hist[0] = instruction that was in execute one cycle ago, hist[1] = two ago
  prod_t hist[$];
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] ra);
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i].rw && hist[i].rd != 0 && hist[i].rd == ra)
        return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_lw();
    return (e_resultsrc == 2'b01) && e_regwrite && (e_rd != 0) &&
           ((e_rd == d_ra1) || (e_rd == d_ra2));
  endfunction

  function automatic int sat(input int v, input int width);
    int mx = (1 << width) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      hist.push_front('{rd: e_rd, rw: e_regwrite});
      if (hist.size() > 2) void'(hist.pop_back());
      if (cnt_clr) begin
        m_stall <= 0;
        m_flush <= 0;
      end else begin
        if (exp_lw() && !e_pcsrc) m_stall <= m_stall + 1;
        if (e_pcsrc) m_flush <= m_flush + 1;
      end
    end
  end

  // Compare process: every negedge, inputs are stable since posedge+2.
  always @(negedge clk) begin
    logic lw;
    lw = exp_lw();
    chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(e_ra1)));
    chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(e_ra2)));
    chk("stall_f", 32'(stall_f), 32'(lw && !e_pcsrc));
    chk("stall_d", 32'(stall_d), 32'(lw && !e_pcsrc));
    chk("flush_d", 32'(flush_d), 32'(e_pcsrc));
    chk("flush_e", 32'(flush_e), 32'(lw || e_pcsrc));
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, 16)));
    chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, 16)));
    chk("stall_cnt4", 32'(stall_cnt4), 32'(sat(m_stall, 4)));
    chk("flush_cnt4", 32'(flush_cnt4), 32'(sat(m_flush, 4)));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_e(input logic [4:0] rd, input logic rw, input logic [1:0] rs);
    e_rd = rd;
    e_regwrite = rw;
    e_resultsrc = rs;
  endtask

  typedef struct packed {
    logic [4:0] d_ra1, d_ra2, e_ra1, e_ra2, e_rd;
    logic rw;
    logic [1:0] rs;
    logic pc;
    logic clr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Reset state
    #1;
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_flush_e", 32'(flush_e), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    #10 rst_n = 1'b1;
    tick();

    // Back-to-back ALU forwarding
    set_e(5, 1, 2'b00);
    tick();
    set_e(0, 0, 2'b00);
    e_ra1 = 5;
    #1 chk("alu_fwd_mem", 32'(fwd_a), 32'(2'b10));
    tick();
    #1 chk("alu_fwd_wb", 32'(fwd_a), 32'(2'b01));
    tick();
    #1 chk("alu_fwd_none", 32'(fwd_a), 32'(2'b00));
    e_ra1 = 0;

    // Priority: memory stage over writeback
    set_e(7, 1, 2'b00);
    tick();
    tick();
    set_e(0, 0, 2'b00);
    e_ra2 = 7;
    #1 chk("prio_fwd_b", 32'(fwd_b), 32'(2'b10));
    // x0 never forwards
    set_e(0, 1, 2'b00);
    e_ra2 = 0;
    tick();
    set_e(0, 0, 2'b00);
    #1 chk("x0_fwd_a", 32'(fwd_a), 32'(2'b00));
    chk("x0_fwd_b", 32'(fwd_b), 32'(2'b00));

    // Load-use
    set_e(3, 1, 2'b01);
    d_ra2 = 3;
    #1 chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_flush_e", 32'(flush_e), 1);
    chk("lu_flush_d", 32'(flush_d), 0);
    tick();
    set_e(0, 0, 2'b00);
    #1 chk("lu_bubble_stall", 32'(stall_d), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    tick();
    d_ra2 = 0;
    e_ra2 = 3;
    #1 chk("lu_fwd_wb", 32'(fwd_b), 32'(2'b01));
    e_ra2 = 0;

    // Branch flush, with a load-use pending too
    set_e(4, 1, 2'b01);
    d_ra1 = 4;
    e_pcsrc = 1;
    #1 chk("br_flush_d", 32'(flush_d), 1);
    chk("br_flush_e", 32'(flush_e), 1);
    chk("br_stall_f", 32'(stall_f), 0);
    chk("br_stall_d", 32'(stall_d), 0);
    tick();
    e_pcsrc = 0;
    d_ra1 = 0;
    set_e(0, 0, 2'b00);
    #1 chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 1);

    // Counter saturation
    e_pcsrc = 1;
    repeat (20) tick();
    #1 chk("sat_flush_cnt4", 32'(flush_cnt4), 15);
    chk("sat_flush_cnt16", 32'(flush_cnt), 21);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    e_pcsrc = 0;
    #1 chk("clr_flush_cnt4", 32'(flush_cnt4), 0);
    chk("clr_stall_cnt", 32'(stall_cnt), 0);

    // Async reset mid-cycle
    set_e(5, 1, 2'b00);
    e_pcsrc = 1;
    tick();
    set_e(0, 0, 2'b00);
    e_pcsrc = 0;
    e_ra1 = 5;
    #1 chk("pre_rst_fwd_a", 32'(fwd_a), 32'(2'b10));
    chk("pre_rst_flush_cnt", 32'(flush_cnt), 1);
    rst_n = 0;
    #1 chk("arst_fwd_a", 32'(fwd_a), 32'(2'b00));
    chk("arst_flush_cnt", 32'(flush_cnt), 0);
    chk("arst_flush_cnt4", 32'(flush_cnt4), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    #3 rst_n = 1;
    // First edge after release captures the execute bundle
    set_e(9, 1, 2'b00);
    tick();
    set_e(0, 0, 2'b00);
    e_ra1 = 9;
    #1 chk("post_rst_fwd_a", 32'(fwd_a), 32'(2'b10));

    // Mixed directed vectors, checked by the model every cycle
    //            d_ra1 d_ra2 e_ra1 e_ra2 e_rd rw rs     pc clr
    vecs[0] = '{5'd1, 5'd2, 5'd9, 5'd0, 5'd1, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[1] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{5'd3, 5'd1, 5'd1, 5'd1, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[4] = '{5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[5] = '{5'd6, 5'd6, 5'd2, 5'd6, 5'd6, 1'b0, 2'b01, 1'b1, 1'b0};
    vecs[6] = '{5'd8, 5'd0, 5'd6, 5'd8, 5'd8, 1'b1, 2'b01, 1'b1, 1'b1};
    vecs[7] = '{5'd0, 5'd8, 5'd8, 5'd8, 5'd8, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[8] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[9] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      d_ra1 = vecs[i].d_ra1;
      d_ra2 = vecs[i].d_ra2;
      e_ra1 = vecs[i].e_ra1;
      e_ra2 = vecs[i].e_ra2;
      set_e(vecs[i].e_rd, vecs[i].rw, vecs[i].rs);
      e_pcsrc = vecs[i].pc;
      cnt_clr = vecs[i].clr;
      tick();
    end
    cnt_clr = 0;
    e_pcsrc = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
